// File: rtl/alarm_ringer.sv
// Alarm trigger and ringing controller: detects the alarm minute, rings the buzzer,
// and handles snooze, stop, disarm and the ring auto-timeout.
module alarm_ringer #(
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       alarm_enable,
  input  logic [4:0] time_hr,
  input  logic [5:0] time_min,
  input  logic [5:0] time_sec,
  input  logic [4:0] alarm_hr,
  input  logic [5:0] alarm_min,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snooze_count,
  output logic       timed_out
);

  localparam int unsigned TW = 9;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] ring_timer, ring_timer_nxt;
  logic [TW-1:0] snooze_timer, snooze_timer_nxt;
  logic          beep_phase, beep_phase_nxt;
  logic [CW-1:0] snooze_count_nxt;
  logic          timed_out_nxt;
  logic          buzzer_nxt, ringing_nxt, snoozing_nxt;
  logic          match_d, armed, snooze_btn_d, stop_btn_d;
  logic          match_c, trigger_c, snz_ev_c, stp_ev_c;

  // Event detection; armed blocks a match that is already true when reset releases.
  always_comb begin
    match_c   = alarm_enable & (time_hr == alarm_hr) & (time_min == alarm_min) &
                (time_sec == 6'd0);
    trigger_c = match_c & ~match_d & armed;
    snz_ev_c  = snooze_btn & ~snooze_btn_d;
    stp_ev_c  = stop_btn & ~stop_btn_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ring_timer   <= '0;
      snooze_timer <= '0;
      beep_phase   <= 1'b0;
      snooze_count <= '0;
      timed_out    <= 1'b0;
      buzzer       <= 1'b0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
      match_d      <= 1'b0;
      armed        <= 1'b0;
      snooze_btn_d <= 1'b0;
      stop_btn_d   <= 1'b0;
    end else begin
      state        <= state_nxt;
      ring_timer   <= ring_timer_nxt;
      snooze_timer <= snooze_timer_nxt;
      beep_phase   <= beep_phase_nxt;
      snooze_count <= snooze_count_nxt;
      timed_out    <= timed_out_nxt;
      buzzer       <= buzzer_nxt;
      ringing      <= ringing_nxt;
      snoozing     <= snoozing_nxt;
      match_d      <= match_c;
      armed        <= armed | ~match_c;
      snooze_btn_d <= snooze_btn;
      stop_btn_d   <= stop_btn;
    end
  end

  // Next-state: stop/disarm beats snooze, snooze beats timeout expiry.
  always_comb begin
    state_nxt        = state;
    ring_timer_nxt   = ring_timer;
    snooze_timer_nxt = snooze_timer;
    beep_phase_nxt   = beep_phase;
    snooze_count_nxt = snooze_count;
    timed_out_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (trigger_c) begin
          state_nxt        = RINGING;
          ring_timer_nxt   = TW'(RING_SEC);
          beep_phase_nxt   = 1'b1;
          snooze_count_nxt = '0;
        end
      end
      RINGING: begin
        if (stp_ev_c || !alarm_enable) begin
          state_nxt = IDLE;
        end else if (snz_ev_c && (snooze_count < CW'(MAX_SNOOZE))) begin
          state_nxt        = SNOOZE;
          snooze_timer_nxt = TW'(SNOOZE_SEC);
          snooze_count_nxt = snooze_count + CW'(1);
        end else if (tick_1hz) begin
          if (ring_timer <= TW'(1)) begin
            state_nxt     = IDLE;
            timed_out_nxt = 1'b1;
          end else begin
            ring_timer_nxt = ring_timer - TW'(1);
            beep_phase_nxt = ~beep_phase;
          end
        end
      end
      SNOOZE: begin
        if (stp_ev_c || !alarm_enable) begin
          state_nxt = IDLE;
        end else if (tick_1hz) begin
          if (snooze_timer <= TW'(1)) begin
            state_nxt      = RINGING;
            ring_timer_nxt = TW'(RING_SEC);
            beep_phase_nxt = 1'b1;
          end else begin
            snooze_timer_nxt = snooze_timer - TW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    ringing_nxt  = (state_nxt == RINGING);
    snoozing_nxt = (state_nxt == SNOOZE);
    buzzer_nxt   = ringing_nxt & beep_phase_nxt;
  end

endmodule
